// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : two-stage elastic ALU (AND/OR/ADD/SLT), carry chain split at WIDTH/2.
// Option macro: ALU_PIPE_FLAGS_EN enables the overflow and zero outputs.
// Revision: 1.0
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             A_invert,
  input  logic             B_invert,
  input  logic             cin,
  input  logic [1:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int H  = WIDTH / 2;
  localparam int HW = WIDTH - H;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  logic          s1_valid_q, s1_valid_d;
  logic [HW-1:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d;
  logic [1:0]    op_q, op_d;
  logic [H-1:0]  lo_q, lo_d;
  logic          c_h_q, c_h_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic             adv, accept, load2;
  logic [WIDTH-1:0] a_w, b_w;
  logic [H:0]       lo_sum_w;
  logic [HW-2:0]    hi_low_sum;
  logic             c_msb_in, sum_msb, c_out, ovf, less;
  logic [WIDTH-1:0] res_w;

  // Stage 1: operand prep, low half of the carry chain
  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || adv;
    accept   = in_valid && in_ready;

    a_w      = A_invert ? ~src1 : src1;
    b_w      = B_invert ? ~src2 : src2;
    lo_sum_w = {1'b0, a_w[H-1:0]} + {1'b0, b_w[H-1:0]} + {{H{1'b0}}, cin};

    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    op_d       = op_q;
    lo_d       = lo_q;
    c_h_d      = c_h_q;
    if (accept) begin
      a_hi_d = a_w[WIDTH-1:H];
      b_hi_d = b_w[WIDTH-1:H];
      op_d   = operation;
      c_h_d  = lo_sum_w[H];
      case (operation)
        OP_AND:  lo_d = a_w[H-1:0] & b_w[H-1:0];
        OP_OR:   lo_d = a_w[H-1:0] | b_w[H-1:0];
        default: lo_d = lo_sum_w[H-1:0];
      endcase
    end
  end

  // Stage 2: upper half; the MSB is added separately to expose its carry-in
  always_comb begin
    {c_msb_in, hi_low_sum} = {1'b0, a_hi_q[HW-2:0]} + {1'b0, b_hi_q[HW-2:0]}
                           + {{(HW-1){1'b0}}, c_h_q};
    sum_msb = a_hi_q[HW-1] ^ b_hi_q[HW-1] ^ c_msb_in;
    c_out   = (a_hi_q[HW-1] & b_hi_q[HW-1]) | (c_msb_in & (a_hi_q[HW-1] ^ b_hi_q[HW-1]));
    ovf     = c_msb_in ^ c_out;
    less    = sum_msb ^ ovf;

    case (op_q)
      OP_AND:  res_w = {a_hi_q & b_hi_q, lo_q};
      OP_OR:   res_w = {a_hi_q | b_hi_q, lo_q};
      OP_ADD:  res_w = {sum_msb, hi_low_sum, lo_q};
      OP_SLT:  res_w = {{(WIDTH-1){1'b0}}, less};
      default: res_w = '0;
    endcase

    load2       = adv && s1_valid_q;
    out_valid_d = adv ? s1_valid_q : out_valid_q;
    result_d    = load2 ? res_w : result_q;
    cout_d      = load2 ? (op_q[1] & c_out) : cout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      op_q        <= '0;
      lo_q        <= '0;
      c_h_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      c_h_q       <= c_h_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic overflow_q, overflow_d;
  logic zero_q, zero_d;

  always_comb begin
    overflow_d = load2 ? (op_q[1] & ovf) : overflow_q;
    zero_d     = load2 ? (res_w == '0) : zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign overflow = overflow_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;

endmodule
`default_nettype wire
